pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline register walls (REG1 IF/ID, REG2 ID/EX, REG3 EX/MEM, REG4 MEM/WB).
- Detects load-use hazards, taken branches and data-memory wait states.
- Drives the per-wall flush lines, PC/wall hold lines, a memory-timeout halt and a saturating stall counter.
- Sits beside the wall block; its flush outputs connect directly to do_flush_REG1..4.

Parameters:
MEM_TIMEOUT, 64, consecutive busy cycles in MEM_WAIT before the halt fires (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
iID_ra_addr  input  5  source register ra of the instruction in ID
iID_rt_addr  input  5  source register rt of the instruction in ID
iID_uses_ra  input  1  ID instruction reads ra
iID_uses_rt  input  1  ID instruction reads rt
iEX_do_dm_read  input  1  instruction in EX is a load
iEX_write_reg_addr  input  5  destination register of the EX instruction
iEX_branch_taken  input  1  EX resolved a taken branch/jump
iMEM_dm_busy  input  1  data memory not ready; MEM access incomplete
oPC_stall  output  1  hold PC
oREG1_stall  output  1  hold IF/ID wall
oREG23_stall  output  1  hold ID/EX and EX/MEM walls
do_flush_REG1  output  1  flush IF/ID
do_flush_REG2  output  1  flush ID/EX
do_flush_REG3  output  1  flush EX/MEM
do_flush_REG4  output  1  flush MEM/WB
oMEM_timeout  output  1  sticky; memory wait exceeded MEM_TIMEOUT
oSTALL_count  output  CNT_W  saturating count of cycles with oPC_stall=1

Behaviour:
- State register: RUN, MEM_WAIT, HALT. State and counters update on posedge clock. Hazard outputs are combinational from the state and the current inputs, with zero latency.
- Reset (reset==0 at a posedge):
  - State becomes RUN; wait counter, oMEM_timeout and oSTALL_count become 0.
  - While reset==0, all four flush outputs are 1 and all stall outputs are 0.
  - Reset mid-wait or in HALT returns to RUN on the next edge.
- Load-use condition (LU): iEX_do_dm_read && iEX_write_reg_addr!=0 && ((iID_uses_ra && iID_ra_addr==iEX_write_reg_addr) || (iID_uses_rt && iID_rt_addr==iEX_write_reg_addr)).
- RUN, priority highest first:
  1. iMEM_dm_busy: outputs oPC_stall=oREG1_stall=oREG23_stall=1, do_flush_REG4=1, other flushes 0. Next state MEM_WAIT, wait counter becomes 1.
  2. iEX_branch_taken: outputs do_flush_REG1=do_flush_REG2=1, no stalls. Stay in RUN. The branch wins over a simultaneous LU because the dependent instruction is flushed.
  3. LU: outputs oPC_stall=oREG1_stall=1, do_flush_REG2=1 (one bubble). Stay in RUN. The bubble clears LU the next cycle.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - Outputs are the same as RUN case 1, regardless of the branch and LU inputs. Those inputs are held by the stalled stages and are re-evaluated after return to RUN.
  - iMEM_dm_busy==0: outputs 0 this cycle and the RUN rules apply combinationally (branch/LU may act the same cycle). Next state RUN, counter cleared.
  - Busy and counter==MEM_TIMEOUT-1: next state HALT, oMEM_timeout set to 1.
  - Busy otherwise: counter increments. It is 8 bits and never wraps because it exits at the limit.
- HALT: oPC_stall=oREG1_stall=oREG23_stall=1, do_flush_REG4=1. oMEM_timeout stays 1. All inputs are ignored; only reset exits.
- oSTALL_count increments on every posedge where oPC_stall==1 and reset==1, and saturates at all-ones. It is never cleared except by reset.

Test Plan:
- Reset held 2 cycles -> all flushes=1, stalls=0, oSTALL_count=0, oMEM_timeout=0; release -> all outputs 0 with idle inputs.
- Load r5 in EX, ID uses_ra with ra=5 -> exactly 1 cycle of oPC_stall=oREG1_stall=do_flush_REG2=1, oSTALL_count=1. Same case with r0 as the load destination -> no stall.
- iEX_branch_taken=1 together with LU true -> do_flush_REG1=do_flush_REG2=1, oPC_stall=0, oSTALL_count unchanged.
- iMEM_dm_busy high 5 cycles with iEX_branch_taken=1 throughout -> 5 stall cycles with flush_REG4=1 and no REG1/REG2 flush; on the cycle busy drops, flush_REG1/2=1 and state is RUN; oSTALL_count=5.
- MEM_TIMEOUT=4, busy held high -> oMEM_timeout=1 after the 4th busy cycle. Stalls persist after busy drops; reset low 1 cycle clears the halt.
- CNT_W=4, 20 stall cycles -> oSTALL_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the four pipeline register walls: load-use bubbles,
// taken-branch flushes, data-memory wait stalls with a timeout halt, and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       iID_ra_addr,
    input  logic [4:0]       iID_rt_addr,
    input  logic             iID_uses_ra,
    input  logic             iID_uses_rt,
    input  logic             iEX_do_dm_read,
    input  logic [4:0]       iEX_write_reg_addr,
    input  logic             iEX_branch_taken,
    input  logic             iMEM_dm_busy,
    output logic             oPC_stall,
    output logic             oREG1_stall,
    output logic             oREG23_stall,
    output logic             do_flush_REG1,
    output logic             do_flush_REG2,
    output logic             do_flush_REG3,
    output logic             do_flush_REG4,
    output logic             oMEM_timeout,
    output logic [CNT_W-1:0] oSTALL_count
);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             run_rules;

    assign load_use = iEX_do_dm_read && (iEX_write_reg_addr != 5'd0) &&
                      ((iID_uses_ra && (iID_ra_addr == iEX_write_reg_addr)) ||
                       (iID_uses_rt && (iID_rt_addr == iEX_write_reg_addr)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        run_rules     = 1'b0;
        oPC_stall     = 1'b0;
        oREG1_stall   = 1'b0;
        oREG23_stall  = 1'b0;
        do_flush_REG1 = 1'b0;
        do_flush_REG2 = 1'b0;
        do_flush_REG3 = 1'b0;
        do_flush_REG4 = 1'b0;

        unique case (state_q)
            StRun: begin
                if (iMEM_dm_busy) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            StMemWait: begin
                if (!iMEM_dm_busy) begin
                    // Memory finished: the held branch/LU inputs act in this same cycle.
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                    run_rules  = 1'b1;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StHalt: ;
            default: state_d = StRun;
        endcase

        if (run_rules) begin
            if (iEX_branch_taken) begin
                do_flush_REG1 = 1'b1;
                do_flush_REG2 = 1'b1;
            end else if (load_use) begin
                oPC_stall     = 1'b1;
                oREG1_stall   = 1'b1;
                do_flush_REG2 = 1'b1;
            end
        end else begin
            oPC_stall     = 1'b1;
            oREG1_stall   = 1'b1;
            oREG23_stall  = 1'b1;
            do_flush_REG4 = 1'b1;
        end

        if (!reset) begin
            oPC_stall     = 1'b0;
            oREG1_stall   = 1'b0;
            oREG23_stall  = 1'b0;
            do_flush_REG1 = 1'b1;
            do_flush_REG2 = 1'b1;
            do_flush_REG3 = 1'b1;
            do_flush_REG4 = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (oPC_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign oMEM_timeout = timeout_q;
    assign oSTALL_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default-ish and small timeout/counter) driven in
// parallel, checked every cycle against a rule-level model plus directed literal checks.
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] ra, rt, ex_wa;
    logic       uses_ra, uses_rt, ex_rd, br, busy;

    logic        a_pc, a_r1, a_r23, a_f1, a_f2, a_f3, a_f4, a_to;
    logic [15:0] a_cnt;
    logic        b_pc, b_r1, b_r23, b_f1, b_f2, b_f3, b_f4, b_to;
    logic [3:0]  b_cnt;
    logic [6:0]  a_vec, b_vec;

    assign a_vec = {a_pc, a_r1, a_r23, a_f1, a_f2, a_f3, a_f4};
    assign b_vec = {b_pc, b_r1, b_r23, b_f1, b_f2, b_f3, b_f4};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset),
        .iID_ra_addr(ra), .iID_rt_addr(rt), .iID_uses_ra(uses_ra), .iID_uses_rt(uses_rt),
        .iEX_do_dm_read(ex_rd), .iEX_write_reg_addr(ex_wa), .iEX_branch_taken(br),
        .iMEM_dm_busy(busy),
        .oPC_stall(a_pc), .oREG1_stall(a_r1), .oREG23_stall(a_r23),
        .do_flush_REG1(a_f1), .do_flush_REG2(a_f2), .do_flush_REG3(a_f3), .do_flush_REG4(a_f4),
        .oMEM_timeout(a_to), .oSTALL_count(a_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset),
        .iID_ra_addr(ra), .iID_rt_addr(rt), .iID_uses_ra(uses_ra), .iID_uses_rt(uses_rt),
        .iEX_do_dm_read(ex_rd), .iEX_write_reg_addr(ex_wa), .iEX_branch_taken(br),
        .iMEM_dm_busy(busy),
        .oPC_stall(b_pc), .oREG1_stall(b_r1), .oREG23_stall(b_r23),
        .do_flush_REG1(b_f1), .do_flush_REG2(b_f2), .do_flush_REG3(b_f3), .do_flush_REG4(b_f4),
        .oMEM_timeout(b_to), .oSTALL_count(b_cnt)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: per instance a mode flag pair, busy-run length, sticky timeout, stall count.
    int m_waiting [2] = '{0, 0};
    int m_halted  [2] = '{0, 0};
    int m_busy_n  [2] = '{0, 0};
    int m_to      [2] = '{0, 0};
    int m_cnt     [2] = '{0, 0};
    int lim       [2] = '{64, 4};
    int cmax      [2] = '{65535, 15};

    function automatic bit lu_now();
        if (!ex_rd || ex_wa == 0) return 0;
        return (uses_ra && ra == ex_wa) || (uses_rt && rt == ex_wa);
    endfunction

    // Bit order {pc, reg1, reg23, f1, f2, f3, f4}.
    function automatic logic [6:0] exp_out(int k);
        if (!reset) return 7'b0001111;
        if (m_halted[k] || busy) return 7'b1110001;
        if (br) return 7'b0001100;
        if (lu_now()) return 7'b1100100;
        return 7'b0000000;
    endfunction

    task automatic cmp_one(input int k, input string tag, input logic [6:0] av,
                           input logic ato, input logic [31:0] acnt);
        logic [6:0] e;
        e = exp_out(k);
        check({tag, "_outputs"}, 32'(av), 32'(e));
        check({tag, "_timeout"}, 32'(ato), 32'(m_to[k]));
        check({tag, "_stall_count"}, acnt, 32'(m_cnt[k]));
        if (!reset) begin
            m_waiting[k] = 0; m_halted[k] = 0; m_busy_n[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
        end else begin
            if (e[6] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (!m_halted[k]) begin
                if (busy) begin
                    m_busy_n[k]++;
                    m_waiting[k] = 1;
                    if (m_busy_n[k] >= lim[k]) begin
                        m_halted[k] = 1;
                        m_to[k] = 1;
                    end
                end else begin
                    m_waiting[k] = 0;
                    m_busy_n[k] = 0;
                end
            end
        end
    endtask

    always @(negedge clock) begin
        cmp_one(0, "a", a_vec, a_to, 32'(a_cnt));
        cmp_one(1, "b", b_vec, b_to, 32'(b_cnt));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ra = 5'd0; rt = 5'd0; uses_ra = 1'b0; uses_rt = 1'b0;
        ex_rd = 1'b0; ex_wa = 5'd0; br = 1'b0; busy = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) tick();
        check("reset_outputs", 32'(a_vec), 32'h0f);
        check("reset_count", 32'(a_cnt), 0);
        check("reset_timeout", 32'(a_to), 0);
        reset = 1'b1;
        tick();
        check("idle_outputs", 32'(a_vec), 0);

        // Load-use on ra=r5: one bubble.
        ex_rd = 1'b1; ex_wa = 5'd5; ra = 5'd5; uses_ra = 1'b1;
        #1 check("lu_outputs", 32'(a_vec), 32'h64);
        tick();
        idle();
        #1 check("lu_count", 32'(a_cnt), 1);
        check("lu_cleared", 32'(a_vec), 0);

        ex_rd = 1'b1; ex_wa = 5'd0; ra = 5'd0; uses_ra = 1'b1;
        #1 check("lu_r0_no_stall", 32'(a_vec), 0);
        tick();

        ex_wa = 5'd5; ra = 5'd5; br = 1'b1;
        #1 check("branch_beats_lu", 32'(a_vec), 32'h0c);
        tick();
        idle();
        #1 check("branch_count_same", 32'(a_cnt), 1);

        // Five busy cycles with a held taken branch.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            busy = 1'b1; br = 1'b1;
            #1 check("memwait_outputs", 32'(a_vec), 32'h71);
            tick();
        end
        busy = 1'b0;
        #1 check("memwait_exit_branch", 32'(a_vec), 32'h0c);
        check("memwait_count", 32'(a_cnt), 5);
        check("b_halted_timeout", 32'(b_to), 1);
        check("b_halted_outputs", 32'(b_vec), 32'h71);
        tick();
        idle();

        // Timeout on the MEM_TIMEOUT=4 instance.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        busy = 1'b1;
        repeat (3) tick();
        check("timeout_early", 32'(b_to), 0);
        tick();
        check("timeout_set", 32'(b_to), 1);
        check("a_no_timeout", 32'(a_to), 0);
        busy = 1'b0;
        #1 check("halt_persists", 32'(b_vec), 32'h71);
        check("a_resumes", 32'(a_vec), 0);
        tick();
        reset = 1'b0;
        #1 check("halt_reset_outputs", 32'(b_vec), 32'h0f);
        tick();
        reset = 1'b1;
        #1 check("halt_cleared_to", 32'(b_to), 0);
        check("halt_cleared_out", 32'(b_vec), 0);

        // Twenty stall cycles: 4-bit counter saturates.
        busy = 1'b1;
        repeat (20) tick();
        check("sat_b_count", 32'(b_cnt), 15);
        check("sat_a_count", 32'(a_cnt), 20);
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Randomized traffic, checked by the per-cycle model.
        repeat (3000) begin
            reset   = ($urandom_range(0, 149) != 0);
            ra      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            uses_ra = 1'($urandom_range(0, 1));
            uses_rt = 1'($urandom_range(0, 1));
            ex_rd   = 1'($urandom_range(0, 1));
            ex_wa   = 5'($urandom_range(0, 3));
            br      = ($urandom_range(0, 4) == 0);
            busy    = ($urandom_range(0, 5) == 0) || ($urandom_range(0, 99) < 3 && busy);
            tick();
        end
        idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
